// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI3 write-path checker: error indices, response codes
// and the first-error priority helper.
package axi_chk_pkg;

  localparam int ERR_W = 10;

  typedef enum logic [3:0] {
    AW_UNSTABLE   = 4'd0,
    W_UNSTABLE    = 4'd1,
    B_UNSTABLE    = 4'd2,
    WLAST_EARLY   = 4'd3,
    WLAST_MISSING = 4'd4,
    WID_MISMATCH  = 4'd5,
    W_NO_AW       = 4'd6,
    B_NO_W        = 4'd7,
    B_ID_MISMATCH = 4'd8,
    OVERFLOW      = 4'd9
  } axi_wr_err_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_bresp_e;

  // Lowest set index wins when several errors land in the same cycle.
  function automatic logic [3:0] lowest_err(input logic [ERR_W-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_chk_fifo.sv
// Small synchronous FIFO used for the outstanding-AW queue and the completed-ID queue.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axi_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/axi_wr_chk.sv
// Passive AXI3 write-path checker: AW/W/B stability, burst beat/WLAST/WID tracking, B accounting.
// Define AXI_WR_CHK_BORDER_EN to also check that B responses return in burst-completion ID order.
module axi_wr_chk
  import axi_chk_pkg::*;
#(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 4,
  parameter int MAX_OUTS = 8,
  localparam int STRB_W  = DATA_W / 8,
  localparam int CNT_W   = $clog2(MAX_OUTS) + 1
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awbrust,
  input  logic              awvalid,
  input  logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrob,
  input  logic              wlast,
  input  logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  input  logic              bready,
  input  logic              clr_err,
  output logic [ERR_W-1:0]  err_vec,
  output logic              err_pulse,
  output logic [3:0]        first_err_code,
  output logic              first_err_vld,
  output logic [CNT_W-1:0]  outs_cnt,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int AW_PL_W = ID_W + ADDR_W + LEN_W + 5;
  localparam int W_PL_W  = ID_W + DATA_W + STRB_W + 1;
  localparam int B_PL_W  = ID_W + 2;

  logic [AW_PL_W-1:0] aw_pl_p0, aw_pl_p1;
  logic [W_PL_W-1:0]  w_pl_p0, w_pl_p1;
  logic [B_PL_W-1:0]  b_pl_p0, b_pl_p1;
  logic               aw_stall_p1, w_stall_p1, b_stall_p1;

  logic               aw_fire, w_fire, b_fire;
  logic               q_full, q_empty, q_push, q_pop;
  logic [ID_W+LEN_W-1:0] q_head;
  logic [ID_W-1:0]    head_id;
  logic [LEN_W-1:0]   head_len;
  logic [LEN_W-1:0]   beat;
  logic               aw_acc, w_act, close, close_acc, b_ok;
  logic               done_full, done_empty, b_id_err;
  logic [ERR_W-1:0]   new_bits;

  // ---- stage 0: handshake decode and burst tracking on the sampled channel values
  assign aw_pl_p0 = {awid, awaddr, awlen, awsize, awbrust};
  assign w_pl_p0  = {wid, wdata, wstrob, wlast};
  assign b_pl_p0  = {bid, bresp};

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign b_fire  = bvalid && bready;

  // An AW firing into an empty queue is visible as the head in the same cycle.
  assign aw_acc   = aw_fire && !q_full;
  assign head_id  = q_empty ? awid  : q_head[ID_W+LEN_W-1:LEN_W];
  assign head_len = q_empty ? awlen : q_head[LEN_W-1:0];
  assign w_act    = w_fire && (!q_empty || aw_acc);
  assign close    = w_act && (wlast || (beat == head_len));
  assign q_push   = aw_acc && !(q_empty && close);
  assign q_pop    = close && !q_empty;

  assign b_ok      = b_fire && !done_empty;
  assign close_acc = close && (!done_full || b_ok);

  axi_chk_fifo #(.WIDTH(ID_W + LEN_W), .DEPTH(MAX_OUTS)) u_aw_fifo (
    .aclk  (aclk),
    .arst  (arst),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({awid, awlen}),
    .full  (q_full),
    .empty (q_empty),
    .count (outs_cnt),
    .head  (q_head)
  );

`ifdef AXI_WR_CHK_BORDER_EN
  logic [ID_W-1:0] idf_head;

  axi_chk_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUTS)) u_id_fifo (
    .aclk  (aclk),
    .arst  (arst),
    .push  (close_acc),
    .pop   (b_ok),
    .din   (head_id),
    .full  (done_full),
    .empty (done_empty),
    .count (done_cnt),
    .head  (idf_head)
  );

  assign b_id_err = b_ok && (bid != idf_head);
`else
  always_ff @(posedge aclk) begin
    if (arst) done_cnt <= '0;
    else      done_cnt <= done_cnt + CNT_W'(close_acc) - CNT_W'(b_ok);
  end

  assign done_full  = (done_cnt == CNT_W'(MAX_OUTS));
  assign done_empty = (done_cnt == '0);
  assign b_id_err   = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (arst)       beat <= '0;
    else if (close) beat <= '0;
    else if (w_act) beat <= beat + LEN_W'(1);
  end

  always_comb begin
    new_bits                = '0;
    new_bits[AW_UNSTABLE]   = aw_stall_p1 && (!awvalid || (aw_pl_p0 != aw_pl_p1));
    new_bits[W_UNSTABLE]    = w_stall_p1  && (!wvalid  || (w_pl_p0  != w_pl_p1));
    new_bits[B_UNSTABLE]    = b_stall_p1  && (!bvalid  || (b_pl_p0  != b_pl_p1));
    new_bits[WLAST_EARLY]   = w_act && wlast && (beat < head_len);
    new_bits[WLAST_MISSING] = w_act && !wlast && (beat == head_len);
    new_bits[WID_MISMATCH]  = w_act && (wid != head_id);
    new_bits[W_NO_AW]       = w_fire && !w_act;
    new_bits[B_NO_W]        = b_fire && done_empty;
    new_bits[B_ID_MISMATCH] = b_id_err;
    new_bits[OVERFLOW]      = (aw_fire && q_full) || (close && done_full);
  end

  // ---- stage 1: previous-cycle channel snapshot and sticky error state
  always_ff @(posedge aclk) begin
    aw_pl_p1 <= aw_pl_p0;
    w_pl_p1  <= w_pl_p0;
    b_pl_p1  <= b_pl_p0;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      aw_stall_p1    <= 1'b0;
      w_stall_p1     <= 1'b0;
      b_stall_p1     <= 1'b0;
      err_vec        <= '0;
      err_pulse      <= 1'b0;
      first_err_code <= '0;
      first_err_vld  <= 1'b0;
    end else begin
      aw_stall_p1 <= awvalid && !awready;
      w_stall_p1  <= wvalid && !wready;
      b_stall_p1  <= bvalid && !bready;
      err_vec     <= (clr_err ? '0 : err_vec) | new_bits;
      err_pulse   <= |(new_bits & ~err_vec);
      if ((clr_err || !first_err_vld) && (|new_bits)) begin
        first_err_code <= lowest_err(new_bits);
        first_err_vld  <= 1'b1;
      end else if (clr_err) begin
        first_err_code <= '0;
        first_err_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_chk.sv
// Bench for axi_wr_chk: directed scenarios plus randomized legal/near-legal traffic,
// every cycle compared against a queue-based reference model of the checking rules.
module tb_axi_wr_chk;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4, MAX_OUTS = 8;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTS) + 1;

  logic              aclk = 1'b0;
  logic              arst = 1'b1;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [LEN_W-1:0]  awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awbrust = '0;
  logic              awvalid = 1'b0, awready = 1'b0;
  logic [ID_W-1:0]   wid = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [STRB_W-1:0] wstrob = '0;
  logic              wlast = 1'b0, wvalid = 1'b0, wready = 1'b0;
  logic [ID_W-1:0]   bid = '0;
  logic [1:0]        bresp = '0;
  logic              bvalid = 1'b0, bready = 1'b0;
  logic              clr_err = 1'b0;
  logic [9:0]        err_vec;
  logic              err_pulse;
  logic [3:0]        first_err_code;
  logic              first_err_vld;
  logic [CNT_W-1:0]  outs_cnt, done_cnt;

  axi_wr_chk #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUTS(MAX_OUTS)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awbrust(awbrust),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrob(wstrob), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .clr_err(clr_err), .err_vec(err_vec), .err_pulse(err_pulse),
    .first_err_code(first_err_code), .first_err_vld(first_err_vld),
    .outs_cnt(outs_cnt), .done_cnt(done_cnt)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  typedef struct { logic [3:0] id; logic [3:0] len; } aw_t;
  aw_t        awq[$];
  logic [3:0] doneq[$];
  int         beat = 0;
  logic [9:0] m_err = '0;
  logic       m_pulse = 1'b0;
  logic [3:0] m_code = '0;
  logic       m_fvld = 1'b0;
  logic       p_aws = 1'b0, p_ws = 1'b0, p_bs = 1'b0;
  logic [44:0] p_aw = '0;
  logic [40:0] p_w = '0;
  logic [5:0]  p_b = '0;

  function automatic logic [3:0] lowest(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock of the checker's rules to the inputs about to be sampled.
  task automatic model_step();
    logic [9:0] nb;
    logic       closed;
    logic [3:0] cid;
    int         dn;
    aw_t        e;
    nb = '0;
    closed = 1'b0;
    cid = '0;
    if (arst) begin
      awq.delete(); doneq.delete(); beat = 0;
      m_err = '0; m_pulse = 1'b0; m_code = '0; m_fvld = 1'b0;
      p_aws = 1'b0; p_ws = 1'b0; p_bs = 1'b0;
      return;
    end
    if (p_aws && (!awvalid || {awid, awaddr, awlen, awsize, awbrust} != p_aw)) nb[0] = 1'b1;
    if (p_ws && (!wvalid || {wid, wdata, wstrob, wlast} != p_w)) nb[1] = 1'b1;
    if (p_bs && (!bvalid || {bid, bresp} != p_b)) nb[2] = 1'b1;
    if (awvalid && awready) begin
      if (awq.size() < MAX_OUTS) begin
        e.id = awid; e.len = awlen;
        awq.push_back(e);
      end else nb[9] = 1'b1;
    end
    if (wvalid && wready) begin
      if (awq.size() == 0) nb[6] = 1'b1;
      else begin
        e = awq[0];
        if (wlast && beat < int'(e.len)) nb[3] = 1'b1;
        if (!wlast && beat == int'(e.len)) nb[4] = 1'b1;
        if (wid != e.id) nb[5] = 1'b1;
        if (wlast || beat == int'(e.len)) begin
          closed = 1'b1; cid = e.id;
          void'(awq.pop_front());
          beat = 0;
        end else beat++;
      end
    end
    dn = doneq.size();
    if (bvalid && bready) begin
      if (dn == 0) nb[7] = 1'b1;
      else begin
`ifdef AXI_WR_CHK_BORDER_EN
        if (bid != doneq[0]) nb[8] = 1'b1;
`endif
        void'(doneq.pop_front());
      end
    end
    if (closed) begin
      if (dn == MAX_OUTS) nb[9] = 1'b1;
      if (doneq.size() < MAX_OUTS) doneq.push_back(cid);
    end
    m_pulse = |(nb & ~m_err);
    m_err = clr_err ? nb : (m_err | nb);
    if (clr_err) begin m_fvld = 1'b0; m_code = '0; end
    if (!m_fvld && nb != '0) begin m_fvld = 1'b1; m_code = lowest(nb); end
    p_aws = awvalid && !awready; p_aw = {awid, awaddr, awlen, awsize, awbrust};
    p_ws  = wvalid && !wready;   p_w  = {wid, wdata, wstrob, wlast};
    p_bs  = bvalid && !bready;   p_b  = {bid, bresp};
  endtask

  task automatic cyc();
    model_step();
    @(posedge aclk);
    #1;
    chk("err_vec", 32'(err_vec), 32'(m_err));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("first_err_code", 32'(first_err_code), 32'(m_code));
    chk("first_err_vld", 32'(first_err_vld), 32'(m_fvld));
    chk("outs_cnt", 32'(outs_cnt), 32'(awq.size()));
    chk("done_cnt", 32'(done_cnt), 32'(doneq.size()));
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [3:0] len, input bit rnd);
    awid = id; awlen = len; awaddr = $urandom; awsize = 3'd2; awbrust = 2'd1; awvalid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      awready = (!rnd || t == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      if (awready) break;
    end
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic last, input bit rnd);
    wid = id; wlast = last; wdata = $urandom; wstrob = 4'($urandom); wvalid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      wready = (!rnd || t == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      if (wready) break;
    end
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id, input bit rnd);
    bid = id; bresp = 2'($urandom_range(0, 3)); bvalid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bready = (!rnd || t == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      if (bready) break;
    end
    bvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic clear();
    clr_err = 1'b1; cyc(); clr_err = 1'b0;
  endtask

  initial begin
    logic [3:0] pend[$];
    logic [3:0] id, len, wv;
    logic       exp8;
`ifdef AXI_WR_CHK_BORDER_EN
    exp8 = 1'b1;
`else
    exp8 = 1'b0;
`endif

    // Reset
    arst = 1'b1; cyc(); cyc();
    chk("reset_err_vec", 32'(err_vec), 32'd0);
    chk("reset_outs", 32'(outs_cnt), 32'd0);
    arst = 1'b0; cyc();

    // Clean burst id 3 len 3
    send_aw(4'd3, 4'd3, 1'b0);
    chk("p1_outs_after_aw", 32'(outs_cnt), 32'd1);
    for (int b = 0; b < 4; b++) send_w(4'd3, b == 3, 1'b0);
    chk("p1_outs_after_w", 32'(outs_cnt), 32'd0);
    chk("p1_done_after_w", 32'(done_cnt), 32'd1);
    send_b(4'd3, 1'b0);
    chk("p1_done_after_b", 32'(done_cnt), 32'd0);
    chk("p1_err_vec", 32'(err_vec), 32'd0);

    // Early WLAST, then the next burst starts counting from beat 0
    send_aw(4'd5, 4'd3, 1'b0);
    send_w(4'd5, 1'b0, 1'b0);
    send_w(4'd5, 1'b1, 1'b0);
    chk("p2_wlast_early", 32'(err_vec[3]), 32'd1);
    chk("p2_first_code", 32'(first_err_code), 32'd3);
    chk("p2_pulse", 32'(err_pulse), 32'd1);
    send_aw(4'd2, 4'd1, 1'b0);
    send_w(4'd2, 1'b0, 1'b0);
    send_w(4'd2, 1'b1, 1'b0);
    chk("p2_next_clean", 32'(err_vec), 32'h8);
    send_b(4'd5, 1'b0);
    send_b(4'd2, 1'b0);
    clear();
    chk("clr_err_vec", 32'(err_vec), 32'd0);
    chk("clr_fvld", 32'(first_err_vld), 32'd0);

    // AW payload changes while stalled
    awid = 4'd1; awlen = 4'd0; awaddr = 32'h100; awsize = 3'd2; awbrust = 2'd1;
    awvalid = 1'b1; awready = 1'b0;
    cyc();
    chk("p3_before", 32'(err_vec[0]), 32'd0);
    awaddr = 32'h104;
    cyc();
    chk("p3_unstable", 32'(err_vec[0]), 32'd1);
    chk("p3_pulse_hi", 32'(err_pulse), 32'd1);
    awready = 1'b1;
    cyc();
    chk("p3_pulse_lo", 32'(err_pulse), 32'd0);
    awvalid = 1'b0; awready = 1'b0;
    send_w(4'd1, 1'b1, 1'b0);
    send_b(4'd1, 1'b0);
    clear();

    // Randomized traffic with backpressure and occasional WID corruption
    for (int n = 0; n < 16; n++) begin
      id = 4'($urandom); len = 4'($urandom_range(0, 5));
      send_aw(id, len, 1'b1);
      for (int b = 0; b <= int'(len); b++) begin
        wv = ($urandom_range(0, 9) == 0) ? (id ^ 4'h1) : id;
        send_w(wv, b == int'(len), 1'b1);
      end
      pend.push_back(id);
      if ($urandom_range(0, 1) == 1 || pend.size() >= 4) begin
        while (pend.size() > 0) send_b(pend.pop_front(), 1'b1);
      end
      if (n == 8) clear();
    end
    while (pend.size() > 0) send_b(pend.pop_front(), 1'b1);
    clear();

    // AW queue overflow
    for (int i = 0; i < 9; i++) send_aw(4'(i), 4'd0, 1'b0);
    chk("p4_outs_full", 32'(outs_cnt), 32'd8);
    chk("p4_overflow", 32'(err_vec[9]), 32'd1);
    for (int i = 0; i < 8; i++) send_w(4'(i), 1'b1, 1'b0);
    chk("p4_done_full", 32'(done_cnt), 32'd8);
    for (int i = 0; i < 8; i++) send_b(4'(i), 1'b0);
    clear();

    // B with no completed burst, then out-of-order B
    send_b(4'd0, 1'b0);
    chk("p5_b_no_w", 32'(err_vec[7]), 32'd1);
    send_aw(4'd1, 4'd0, 1'b0);
    send_w(4'd1, 1'b1, 1'b0);
    send_aw(4'd2, 4'd0, 1'b0);
    send_w(4'd2, 1'b1, 1'b0);
    send_b(4'd2, 1'b0);
    chk("p5_b_id", 32'(err_vec[8]), 32'(exp8));
    send_b(4'd2, 1'b0);
    chk("p5_done_empty", 32'(done_cnt), 32'd0);

    // Reset mid-burst, then a fresh burst
    send_aw(4'd4, 4'd7, 1'b0);
    send_w(4'd4, 1'b0, 1'b0);
    send_w(4'd4, 1'b0, 1'b0);
    arst = 1'b1; wid = 4'd4; wvalid = 1'b1; wready = 1'b1;
    cyc();
    arst = 1'b0; wvalid = 1'b0; wready = 1'b0;
    chk("p6_outs", 32'(outs_cnt), 32'd0);
    chk("p6_done", 32'(done_cnt), 32'd0);
    chk("p6_err", 32'(err_vec), 32'd0);
    send_aw(4'd6, 4'd3, 1'b0);
    for (int b = 0; b < 4; b++) send_w(4'd6, b == 3, 1'b0);
    send_b(4'd6, 1'b0);
    chk("p6_fresh_err", 32'(err_vec), 32'd0);
    chk("p6_fresh_outs", 32'(outs_cnt), 32'd0);
    chk("p6_fresh_done", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_chk.md
Name: axi_wr_chk

Overview:
- Synthesizable AXI3 write-path protocol checker.
- Sits passively on the AW/W/B channels between any master and slave in the VIP environment and in the DUT harness.
- Generalises the interface-level valid/ready assertions into parametrised RTL that also tracks bursts:
  - outstanding AW queue
  - W beat counting against awlen
  - WID/WLAST checking
  - B accounting
- Reports violations through sticky, clearable error flags.

Parameters:
ID_W, 4, width of awid/wid/bid
ADDR_W, 32, awaddr width
DATA_W, 32, wdata width; STRB_W = DATA_W/8 is a derived localparam
LEN_W, 4, awlen width (AXI3 burst of 1..16 beats)
MAX_OUTS, 8, outstanding AW depth and completed-burst depth; power of two, >= 2

Ports:
aclk  in  1  clock
arst  in  1  synchronous, active-high reset
awid/awaddr/awlen/awsize/awbrust/awvalid/awready  in  ID_W/ADDR_W/LEN_W/3/2/1/1  AW channel (observed)
wid/wdata/wstrob/wlast/wvalid/wready  in  ID_W/DATA_W/STRB_W/1/1/1  W channel (observed)
bid/bresp/bvalid/bready  in  ID_W/2/1/1  B channel (observed)
clr_err  in  1  clears err_vec, first_err_*
err_vec  out  10  sticky error flags, index per package enum
err_pulse  out  1  high one cycle when any bit newly set
first_err_code  out  4  index of first error since reset/clear
first_err_vld  out  1  first_err_code valid
outs_cnt  out  $clog2(MAX_OUTS)+1  AW accepted, W burst not closed
done_cnt  out  $clog2(MAX_OUTS)+1  W burst closed, B not yet received

Behaviour:
- Reset: arst sampled high at posedge clears every register; all outputs 0 on the following cycle. Reset mid-burst discards all tracking; no error is raised for abandoned bursts.
- Handshake: a channel fires when valid&&ready at posedge.
- Detection latency: violations are evaluated on the values sampled at posedge N; err_vec and err_pulse update at N+1.
- Error indices:
  - 0 AW_UNSTABLE: previous cycle awvalid&&!awready, and now awvalid=0 or any AW payload differs.
  - 1 W_UNSTABLE: same rule, W payload.
  - 2 B_UNSTABLE: same rule, bid/bresp.
  - 3 WLAST_EARLY: wlast=1 on beat < head awlen.
  - 4 WLAST_MISSING: wlast=0 on beat == head awlen.
  - 5 WID_MISMATCH: wid != head awid.
  - 6 W_NO_AW: W fires while the AW queue is empty and no AW fires in the same cycle.
  - 7 B_NO_W: B fires while done_cnt == 0.
  - 8 B_ID_MISMATCH: see Optional Feature.
  - 9 OVERFLOW: AW fires with outs_cnt == MAX_OUTS, or a burst closes with done_cnt == MAX_OUTS.
- Write data never precedes its AW in this system. A same-cycle AW and first W on an empty queue is legal: the AW bypasses into head position.
- Beat counter: LEN_W bits, reset 0.
  - Increments on each W fire.
  - The burst closes on a W fire with wlast=1 or beat == head awlen, whichever comes first.
  - On close: pop the queue, zero the beat counter, increment done_cnt.
- Dropped events (counters unchanged):
  - W_NO_AW beat is ignored.
  - OVERFLOW AW is dropped.
  - B_NO_W is ignored.
- done_cnt: a burst close and a B fire in the same cycle leave it unchanged.
- outs_cnt: an AW push and a burst close in the same cycle leave it unchanged.
- err_vec bits are sticky.
  - clr_err zeroes err_vec and first_err_vld.
  - If clr_err and a new error occur in the same cycle, the new error bit is set.
- first_err_code: captures the lowest set index when first_err_vld is 0. It holds until clr_err or reset.
- err_pulse: equals |(new_bits & ~err_vec).

Optional Feature:
- AXI_WR_CHK_BORDER_EN defined:
  - A second FIFO (depth MAX_OUTS) records the awid of each closed burst.
  - On B fire with done_cnt > 0, bid must equal the head entry, else bit 8 sets; the entry pops either way.
- Not defined:
  - No ID FIFO is instantiated.
  - Bit 8 is tied 0; only B count is checked.

Decomposition:
- Package axi_chk_pkg holds:
  - ERR_W = 10
  - typedef enum axi_wr_err_e with the indices above
  - a bresp enum (OKAY/EXOKAY/SLVERR/DECERR)
- Sub-module axi_chk_fifo: sync FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty/count/head.
  - Instance 1: {awid, awlen} queue.
  - Instance 2: completed-ID FIFO, only under the macro.

Test Plan:
- AW id=3 len=3, then 4 W beats wid=3 with wlast on beat 3, then B bid=3 → err_vec=0; outs_cnt 1→0; done_cnt 1→0.
- AW len=3, wlast=1 on beat 1 → err_vec[3]=1; first_err_code=3; next burst counts from beat 0.
- awvalid high with awready=0, awaddr changes 0x100→0x104 next cycle → err_vec[0]=1 with 1-cycle latency; err_pulse one cycle.
- 9 AWs with MAX_OUTS=8 and no W → err_vec[9]=1; outs_cnt stays 8.
- B with no completed burst → err_vec[7]=1. Under the macro: bursts id 1 then 2, B bid=2 first → err_vec[8]=1.
- arst asserted mid-burst (beat 2 of len 7) → all counts and err_vec 0 next cycle; the following fresh burst passes clean.
